run_sequencer: RTL

Synthesizable reset-sequencing and run-supervision block that sits between the board clock/reset inputs and the CPU core and peripheral domains of `riscv_top`. It holds all downstream domains in reset for a programmable time, then releases NCH reset channels in a staggered order. It then counts run cycles until the core reports halt or a cycle limit expires. It replaces fixed hold/run lengths with parameters, multi-channel release, halt detection, timeout reporting and a synchronous soft-restart.

---
 rtl/run_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/run_sequencer.sv
// run_sequencer: staggered reset release followed by supervised run with halt/timeout detection
module run_sequencer #(
  parameter int NCH         = 2,
  parameter int HOLD_CYCLES = 25,
  parameter int STAGGER     = 4,
  parameter int CNT_W       = 32,
  parameter int MAX_CYCLES  = 10000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             soft_rst,
  input  logic             halt_i,
  output logic [NCH-1:0]   rst_out,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt
);
  typedef enum logic [2:0] {HOLD, STAGE, RUN, DONE, TIMEOUT} state_t;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STAGGER + 1);
  localparam int CW = $clog2(NCH + 1);
  localparam logic [CNT_W:0] LIM = (CNT_W+1)'(MAX_CYCLES);
  state_t state, state_n;
  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic [SW-1:0] stg_cnt, stg_cnt_n;
  logic [CW-1:0] ch, ch_n;
  logic [NCH-1:0] rst_out_n;
  logic running_n, done_n, timeout_n;
  logic [CNT_W-1:0] cycle_cnt_n;
  // state and output registers, all cleared asynchronously
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      stg_cnt   <= '0;
      ch        <= '0;
      rst_out   <= '1;
      running   <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      state     <= state_n;
      hold_cnt  <= hold_cnt_n;
      stg_cnt   <= stg_cnt_n;
      ch        <= ch_n;
      rst_out   <= rst_out_n;
      running   <= running_n;
      done      <= done_n;
      timeout   <= timeout_n;
      cycle_cnt <= cycle_cnt_n;
    end
  // next-state and next-output logic; soft restart overrides every transition
  always_comb begin
    state_n     = state;
    hold_cnt_n  = hold_cnt;
    stg_cnt_n   = stg_cnt;
    ch_n        = ch;
    rst_out_n   = rst_out;
    running_n   = running;
    done_n      = done;
    timeout_n   = timeout;
    cycle_cnt_n = cycle_cnt;
    if (soft_rst) begin
      state_n     = HOLD;
      hold_cnt_n  = '0;
      stg_cnt_n   = '0;
      ch_n        = '0;
      rst_out_n   = '1;
      running_n   = 1'b0;
      done_n      = 1'b0;
      timeout_n   = 1'b0;
      cycle_cnt_n = '0;
    end else begin
      case (state)
        HOLD: begin
          hold_cnt_n = hold_cnt + 1'b1;
          if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            rst_out_n[0] = 1'b0;
            stg_cnt_n    = '0;
            ch_n         = CW'(1);
            state_n      = (NCH == 1) ? RUN : STAGE;
            running_n    = (NCH == 1);
          end
        end
        STAGE: begin
          stg_cnt_n = stg_cnt + 1'b1;
          if (stg_cnt == SW'(STAGGER - 1)) begin
            rst_out_n = rst_out & ~(NCH'(1) << ch);
            ch_n      = ch + 1'b1;
            stg_cnt_n = '0;
            if (ch == CW'(NCH - 1)) begin
              state_n   = RUN;
              running_n = 1'b1;
            end
          end
        end
        RUN: begin
          if (halt_i) begin
            state_n   = DONE;
            running_n = 1'b0;
            done_n    = 1'b1;
          end else begin
            cycle_cnt_n = &cycle_cnt ? cycle_cnt : cycle_cnt + 1'b1;
            if (MAX_CYCLES != 0 && {1'b0, cycle_cnt} + 1'b1 == LIM) begin
              state_n   = TIMEOUT;
              running_n = 1'b0;
              timeout_n = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
